// File: rtl/ecc_163_enc_fault_detc.sv
// SECDED write-side encoder with lockstep fault detection.
// ecc_163_cal: Hamming(8) + overall-parity generator/checker for 163-bit words.
// ecc_163_enc_fault_detc: one valid/ready stage. Two encoders run in lockstep and are compared.
// Optional macro ECC_ENC_FAULT_INJ_EN adds inj_en/inj_mask ports for compare-path fault injection.

module ecc_163_cal #(
  parameter int DATA_WIDTH   = 163,
  parameter int PARITY_WIDTH = 9
) (
  input  logic [DATA_WIDTH-1:0]   data_i,
  input  logic [PARITY_WIDTH-1:0] parity_i,
  output logic [PARITY_WIDTH-1:0] parity_o,
  output logic                    sbit_err_o,
  output logic                    dbit_err_o
);
  localparam int HAM_W = PARITY_WIDTH - 1;

  // Data bit k occupies the k-th non-power-of-two codeword position (3,5,6,7,9,...).
  // Its Hamming contribution is that position number.
  function automatic logic [DATA_WIDTH*HAM_W-1:0] build_pos();
    logic [DATA_WIDTH*HAM_W-1:0] t;
    int k;
    t = '0;
    k = 0;
    for (int p = 1; p < (1 << HAM_W); p++) begin
      if (((p & (p - 1)) != 0) && (k < DATA_WIDTH)) begin
        t[k*HAM_W +: HAM_W] = p[HAM_W-1:0];
        k++;
      end
    end
    return t;
  endfunction

  localparam logic [DATA_WIDTH*HAM_W-1:0] POS_TABLE = build_pos();

  logic [HAM_W-1:0] ham;
  logic [HAM_W-1:0] syndrome;
  logic             overall_odd;

  // Hamming check bits are the XOR of the positions of all set data bits.
  always_comb begin
    ham = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (data_i[i]) ham = ham ^ POS_TABLE[i*HAM_W +: HAM_W];
    end
  end

  // The overall bit makes the full codeword even parity.
  assign parity_o    = {(^data_i) ^ (^ham), ham};
  assign syndrome    = ham ^ parity_i[HAM_W-1:0];
  assign overall_odd = (^data_i) ^ (^parity_i);
  assign sbit_err_o  = overall_odd;
  assign dbit_err_o  = ~overall_odd & (|syndrome);
endmodule

module ecc_163_enc_fault_detc #(
  parameter int DATA_WIDTH   = 163,
  parameter int PARITY_WIDTH = 9,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
`ifdef ECC_ENC_FAULT_INJ_EN
  input  logic                    inj_en,
  input  logic [PARITY_WIDTH-1:0] inj_mask,
`endif
  input  logic                    ecc_fault_detc_en,
  input  logic                    bypass,
  input  logic                    fault_clr,
  input  logic                    in_vld,
  output logic                    in_rdy,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic                    out_vld,
  input  logic                    out_rdy,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [PARITY_WIDTH-1:0] out_parity,
  output logic                    ecc_fault,
  output logic                    fault_sticky,
  output logic [CNT_WIDTH-1:0]    fault_cnt
);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [PARITY_WIDTH-1:0] parity0, parity1, parity1_eff;
  logic                    sbit0, dbit0, sbit1, dbit1;
  logic                    unused_cal;
  logic                    capture, fault_now;

  logic                    out_vld_q, out_vld_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic [PARITY_WIDTH-1:0] out_parity_q, out_parity_d;
  logic                    ecc_fault_q, ecc_fault_d;
  logic                    fault_sticky_q, fault_sticky_d;
  logic [CNT_WIDTH-1:0]    fault_cnt_q, fault_cnt_d;

  ecc_163_cal #(.DATA_WIDTH(DATA_WIDTH), .PARITY_WIDTH(PARITY_WIDTH)) u_cal0 (
    .data_i     (in_data),
    .parity_i   ('0),
    .parity_o   (parity0),
    .sbit_err_o (sbit0),
    .dbit_err_o (dbit0)
  );

  ecc_163_cal #(.DATA_WIDTH(DATA_WIDTH), .PARITY_WIDTH(PARITY_WIDTH)) u_cal1 (
    .data_i     (in_data),
    .parity_i   ('0),
    .parity_o   (parity1),
    .sbit_err_o (sbit1),
    .dbit_err_o (dbit1)
  );

  // Only the generated parity is used on the write side; the check outputs are dropped.
  assign unused_cal = sbit0 ^ dbit0 ^ sbit1 ^ dbit1;

`ifdef ECC_ENC_FAULT_INJ_EN
  // Injection perturbs the compare path only; the stored parity always comes from instance 0.
  assign parity1_eff = parity1 ^ (inj_en ? inj_mask : '0);
`else
  assign parity1_eff = parity1;
`endif

  assign in_rdy    = ~rst & (~out_vld_q | out_rdy);
  assign capture   = in_vld & in_rdy;
  assign fault_now = ecc_fault_detc_en & ~bypass & (|(parity0 ^ parity1_eff));

  // Next state: capture loads a new word, a drained output empties, and a stall holds everything.
  always_comb begin
    out_vld_d      = out_vld_q;
    out_data_d     = out_data_q;
    out_parity_d   = out_parity_q;
    ecc_fault_d    = ecc_fault_q;
    fault_sticky_d = fault_sticky_q;
    fault_cnt_d    = fault_cnt_q;
    if (capture) begin
      out_vld_d    = 1'b1;
      out_data_d   = in_data;
      out_parity_d = bypass ? '0 : parity0;
      ecc_fault_d  = fault_now;
    end else if (out_rdy) begin
      out_vld_d = 1'b0;
    end
    if (fault_clr) begin
      fault_sticky_d = 1'b0;
      fault_cnt_d    = '0;
    end
    // A faulty capture in the same cycle as a clear wins over the clear.
    if (capture && fault_now) begin
      fault_sticky_d = 1'b1;
      fault_cnt_d    = (fault_cnt_d == CNT_MAX) ? CNT_MAX : fault_cnt_d + 1'b1;
    end
  end

  // Output stage and fault counters; reset discards any held word.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_q      <= 1'b0;
      out_data_q     <= '0;
      out_parity_q   <= '0;
      ecc_fault_q    <= 1'b0;
      fault_sticky_q <= 1'b0;
      fault_cnt_q    <= '0;
    end else begin
      out_vld_q      <= out_vld_d;
      out_data_q     <= out_data_d;
      out_parity_q   <= out_parity_d;
      ecc_fault_q    <= ecc_fault_d;
      fault_sticky_q <= fault_sticky_d;
      fault_cnt_q    <= fault_cnt_d;
    end
  end

  assign out_vld      = out_vld_q;
  assign out_data     = out_data_q;
  assign out_parity   = out_parity_q;
  assign ecc_fault    = ecc_fault_q;
  assign fault_sticky = fault_sticky_q;
  assign fault_cnt    = fault_cnt_q;
endmodule

// File: tb/tb_ecc_163_enc_fault_detc.sv
// Directed bench for ecc_163_enc_fault_detc; injection steps run when ECC_ENC_FAULT_INJ_EN is defined.
module tb_ecc_163_enc_fault_detc;
  localparam int DW = 163;
  localparam int PW = 9;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          ecc_fault_detc_en, bypass, fault_clr;
  logic          in_vld, in_rdy, out_vld, out_rdy;
  logic [DW-1:0] in_data, out_data;
  logic [PW-1:0] out_parity;
  logic          ecc_fault, fault_sticky;
  logic [CW-1:0] fault_cnt;
`ifdef ECC_ENC_FAULT_INJ_EN
  logic          inj_en;
  logic [PW-1:0] inj_mask;
`endif

  logic [DW-1:0] chk_data;
  logic [PW-1:0] chk_parity_gen;
  logic          chk_sbit, chk_dbit;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ecc_163_enc_fault_detc dut (
    .clk               (clk),
    .rst               (rst),
`ifdef ECC_ENC_FAULT_INJ_EN
    .inj_en            (inj_en),
    .inj_mask          (inj_mask),
`endif
    .ecc_fault_detc_en (ecc_fault_detc_en),
    .bypass            (bypass),
    .fault_clr         (fault_clr),
    .in_vld            (in_vld),
    .in_rdy            (in_rdy),
    .in_data           (in_data),
    .out_vld           (out_vld),
    .out_rdy           (out_rdy),
    .out_data          (out_data),
    .out_parity        (out_parity),
    .ecc_fault         (ecc_fault),
    .fault_sticky      (fault_sticky),
    .fault_cnt         (fault_cnt)
  );

  // Decoder used to confirm that stored codewords decode clean.
  ecc_163_cal #(.DATA_WIDTH(DW), .PARITY_WIDTH(PW)) u_chk (
    .data_i     (chk_data),
    .parity_i   (out_parity),
    .parity_o   (chk_parity_gen),
    .sbit_err_o (chk_sbit),
    .dbit_err_o (chk_dbit)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [DW-1:0] onehot(input int idx);
    logic [DW-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [DW-1:0] rand_word();
    logic [191:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return r[DW-1:0];
  endfunction

  // Single-bit words: Hamming bits equal the codeword position, bit 8 evens the total.
  int            sb_idx [6] = '{0, 1, 2, 3, 4, 162};
  logic [PW-1:0] sb_par [6] = '{9'h103, 9'h105, 9'h106, 9'h007, 9'h109, 9'h0AB};

  initial begin
    logic [DW-1:0] ones;
    logic [DW-1:0] held;
    ones = '1;
    rst = 1'b1; in_vld = 1'b1; in_data = rand_word(); out_rdy = 1'b1;
    ecc_fault_detc_en = 1'b1; bypass = 1'b0; fault_clr = 1'b0;
    chk_data = '0;
`ifdef ECC_ENC_FAULT_INJ_EN
    inj_en = 1'b0; inj_mask = '0;
`endif

    // Reset held two cycles with in_vld asserted.
    for (int c = 0; c < 2; c++) begin
      tick();
      check("rst_in_rdy", in_rdy, 0);
      check("rst_out_vld", out_vld, 0);
      check("rst_cnt", fault_cnt, 0);
    end
    check("rst_out_data", out_data, 0);
    check("rst_out_parity", out_parity, 0);
    check("rst_ecc_fault", ecc_fault, 0);
    check("rst_sticky", fault_sticky, 0);
    rst = 1'b0; in_vld = 1'b0;
    tick();
    check("post_rst_out_vld", out_vld, 0);

    // All-zero word.
    in_vld = 1'b1; in_data = '0;
    #1 check("zero_in_rdy", in_rdy, 1);
    tick();
    check("zero_out_vld", out_vld, 1);
    check("zero_out_data", out_data, 0);
    check("zero_out_parity", out_parity, 0);
    check("zero_ecc_fault", ecc_fault, 0);

    // Back-to-back single-bit words with known parity.
    for (int i = 0; i < 6; i++) begin
      in_data = onehot(sb_idx[i]);
      tick();
      check("onehot_vld", out_vld, 1);
      check("onehot_data", out_data, onehot(sb_idx[i]));
      check("onehot_parity", out_parity, sb_par[i]);
    end
    in_data = onehot(0) | onehot(1);
    tick();
    check("pair_parity", out_parity, 9'h006);

    // Idle with ready drains the stage.
    in_vld = 1'b0;
    tick();
    check("drain_out_vld", out_vld, 0);

    // Stall: one word captured, then held while inputs change.
    out_rdy = 1'b0; in_vld = 1'b1; in_data = onehot(0);
    tick();
    check("stall_cap_vld", out_vld, 1);
    check("stall_cap_data", out_data, onehot(0));
    for (int c = 0; c < 5; c++) begin
      in_data = rand_word();
      ecc_fault_detc_en = c[0];
      #1 check("stall_in_rdy", in_rdy, 0);
      tick();
      check("stall_vld", out_vld, 1);
      check("stall_data", out_data, onehot(0));
      check("stall_parity", out_parity, 9'h103);
      check("stall_fault", ecc_fault, 0);
    end
    ecc_fault_detc_en = 1'b1;
    out_rdy = 1'b1; in_data = onehot(1);
    #1 check("release_in_rdy", in_rdy, 1);
    tick();
    check("order0_data", out_data, onehot(1));
    check("order0_parity", out_parity, 9'h105);
    in_data = onehot(2);
    tick();
    check("order1_data", out_data, onehot(2));
    check("order1_parity", out_parity, 9'h106);
    check("order1_vld", out_vld, 1);

    // Bypass with all-ones payload.
    bypass = 1'b1; in_data = ones;
`ifdef ECC_ENC_FAULT_INJ_EN
    inj_en = 1'b1; inj_mask = 9'h001;
`endif
    tick();
    check("byp_parity", out_parity, 0);
    check("byp_data", out_data, ones);
    check("byp_fault", ecc_fault, 0);
    check("byp_vld", out_vld, 1);
    bypass = 1'b0;
`ifdef ECC_ENC_FAULT_INJ_EN
    inj_en = 1'b0;
`endif

    // Random words decode clean.
    for (int n = 0; n < 200; n++) begin
      in_data = rand_word();
      held = in_data;
      tick();
      chk_data = out_data;
      #1;
      check("rand_data", out_data, held);
      check("rand_sbit", chk_sbit, 0);
      check("rand_dbit", chk_dbit, 0);
    end
    chk_data = out_data ^ onehot(100);
    #1 check("flip100_sbit", chk_sbit, 1);
    check("flip100_dbit", chk_dbit, 0);
    chk_data = out_data ^ onehot(100) ^ onehot(7);
    #1 check("flip2_dbit", chk_dbit, 1);
    check("flip2_sbit", chk_sbit, 0);

    // Lockstep instances agree, so nothing is counted without injection.
    check("nofault_sticky", fault_sticky, 0);
    check("nofault_cnt", fault_cnt, 0);

`ifdef ECC_ENC_FAULT_INJ_EN
    inj_en = 1'b1; inj_mask = 9'h001; ecc_fault_detc_en = 1'b1; in_data = rand_word();
    tick();
    check("inj_fault", ecc_fault, 1);
    check("inj_sticky", fault_sticky, 1);
    check("inj_cnt", fault_cnt, 1);
    ecc_fault_detc_en = 1'b0;
    tick();
    check("inj_off_fault", ecc_fault, 0);
    check("inj_off_cnt", fault_cnt, 1);
    ecc_fault_detc_en = 1'b1;
    for (int n = 0; n < 300; n++) tick();
    check("sat_cnt", fault_cnt, 255);
    fault_clr = 1'b1;
    tick();
    check("clr_fault_cnt", fault_cnt, 1);
    check("clr_fault_sticky", fault_sticky, 1);
    in_vld = 1'b0;
    tick();
    check("clr_cnt", fault_cnt, 0);
    check("clr_sticky", fault_sticky, 0);
    fault_clr = 1'b0; inj_en = 1'b0; in_vld = 1'b1;
`endif

    // Reset while a word is held: it must not reappear.
    out_rdy = 1'b0; in_vld = 1'b1; in_data = onehot(5);
    tick();
    check("midrst_pre_vld", out_vld, 1);
    rst = 1'b1;
    tick();
    check("midrst_vld", out_vld, 0);
    check("midrst_in_rdy", in_rdy, 0);
    rst = 1'b0; in_vld = 1'b0; out_rdy = 1'b1;
    tick();
    check("midrst_after_vld", out_vld, 0);
    check("midrst_data", out_data, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
